// File: rtl/instr_issuer.sv
// Program buffer that issues stored instruction words into a pipeline, followed by a
// NOP drain window and a one-cycle completion pulse.
module instr_issuer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DRAIN = 3,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    LoadEn,
  input  logic [31:0]             LoadData,
  input  logic                    Clear,
  input  logic                    Start,
  input  logic                    Stall,
  output logic [31:0]             InstrOut,
  output logic                    WriteEnable,
  output logic [$clog2(DEPTH):0]  Count,
  output logic [$clog2(DEPTH):0]  PC,
  output logic                    Full,
  output logic                    Busy,
  output logic                    Done,
  output logic                    LoadErr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DW-1:0] DLAST   = DW'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [DW-1:0] dcnt;
  logic          do_write;
  logic          last_issue;

  always_comb begin
    Full       = (Count == DEPTH_C);
    Busy       = (state != S_IDLE);
    do_write   = !Reset && (state == S_IDLE) && LoadEn && !Clear && !Full;
    last_issue = ((PC + CW'(1)) == Count);
  end

  // Buffer storage carries no reset; Count bounds every read.
  always_ff @(posedge Clk) begin
    if (do_write)
      mem[Count[AW-1:0]] <= LoadData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      Count       <= '0;
      PC          <= '0;
      InstrOut    <= NOP;
      WriteEnable <= 1'b0;
      Done        <= 1'b0;
      LoadErr     <= 1'b0;
      dcnt        <= '0;
    end else begin
      InstrOut    <= NOP;
      WriteEnable <= 1'b0;
      Done        <= 1'b0;
      LoadErr     <= 1'b0;
      case (state)
        S_IDLE: begin
          // Clear beats LoadEn, and any load or clear suppresses Start.
          if (Clear) begin
            Count <= '0;
          end else if (LoadEn) begin
            if (!Full)
              Count <= Count + CW'(1);
            else
              LoadErr <= 1'b1;
          end else if (Start && (Count != '0)) begin
            PC    <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            InstrOut    <= mem[PC[AW-1:0]];
            WriteEnable <= 1'b1;
            PC          <= PC + CW'(1);
            if (last_issue) begin
              dcnt  <= '0;
              state <= (DRAIN == 0) ? S_DONE : S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (dcnt == DLAST)
            state <= S_DONE;
          else
            dcnt <= dcnt + DW'(1);
        end
        S_DONE: begin
          // Done rises as the block returns to idle, so it coincides with Busy low.
          Done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the program buffer entry count (power of two, 2..64).
REQ-002 Parameter DRAIN, default 3, SHALL set the number of NOP-issue cycles after the last instruction, covering pipeline depth.
REQ-003 Parameter NOP, default 32'h0000_0000, SHALL be the instruction word driven when not issuing.
REQ-004 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 LoadEn  input  1  SHALL request a buffer write of LoadData this cycle.
REQ-007 LoadData  input  32  SHALL be the instruction word to store (op[31:26], rd[25:21], rs[20:16], imm/rt[15:0]).
REQ-008 Clear  input  1  SHALL empty the buffer (Count to 0) when in IDLE.
REQ-009 Start  input  1  SHALL request issue of the stored program.
REQ-010 Stall  input  1  SHALL hold issue for the current cycle.
REQ-011 InstrOut  output  32  SHALL be the registered instruction word feeding the pipeline InstrIn.
REQ-012 WriteEnable  output  1  SHALL be the registered pipeline WriteEnable, high only when InstrOut carries a buffered instruction.
REQ-013 Count  output  log2(DEPTH)+1  SHALL report stored entries.
REQ-014 PC  output  log2(DEPTH)+1  SHALL report the index of the next entry to issue.
REQ-015 Full, Busy, Done, LoadErr  output  1 each  SHALL report buffer full, state not IDLE, one-cycle completion pulse, one-cycle rejected-write pulse.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN, DONE; all outputs registered, 1-cycle latency from the causing input edge.
REQ-017 IDLE, LoadEn, Count<DEPTH: mem[Count]<=LoadData, Count+1; Count==DEPTH: no write, LoadErr pulses 1 cycle.
REQ-018 Full SHALL equal (Count==DEPTH) combinationally from the Count register.
REQ-019 IDLE, Clear: Count<=0; Clear with LoadEn same cycle: Clear wins, no write, no LoadErr.
REQ-020 IDLE, Start, Count>0, no LoadEn/Clear: PC<=0, go RUN; Start with Count==0 or with LoadEn/Clear same cycle SHALL be ignored.
REQ-021 RUN, Stall low: InstrOut<=mem[PC], WriteEnable<=1, PC+1; when issued entry is Count-1, go DRAIN.
REQ-022 RUN, Stall high: InstrOut<=NOP, WriteEnable<=0, PC held (bubble).
REQ-023 DRAIN: InstrOut<=NOP, WriteEnable<=0 for exactly DRAIN cycles regardless of Stall, then DONE.
REQ-024 DONE: Done=1 for one cycle, next state IDLE; buffer contents and Count retained for re-Start.
REQ-025 LoadEn, Clear, Start outside IDLE SHALL be ignored, no LoadErr.
REQ-026 Issue order SHALL be strictly 0..Count-1, no skips or repeats under any Stall pattern.
REQ-027 PC and Count SHALL never wrap; DEPTH entries issue with PC reaching DEPTH.

Reset
REQ-028 Reset SHALL force IDLE, Count=0, PC=0, InstrOut=NOP, WriteEnable=0, Done=0, LoadErr=0 on the next edge, from any state, overriding all inputs.
REQ-029 Buffer memory SHALL need no reset; contents are unreachable after Reset since Count=0.

Verification
REQ-030 Load 32'h68000005, 32'h6821000A, 32'h6842FFF8; Start, Stall=0 -> InstrOut these three on consecutive cycles with WriteEnable=1, then 3 NOP cycles WriteEnable=0, Done pulse, Busy low.
REQ-031 Same program, Stall high the cycle after first issue -> sequence 68000005, NOP(WE=0), 6821000A, 6842FFF8; no repeat/skip.
REQ-032 Load 17 words at DEPTH=16 -> Count=16, Full=1, LoadErr pulse on 17th only; run issues 16 words, PC ends 16.
REQ-033 Start with Count=0 -> stays IDLE, Busy=0; LoadEn+Start same cycle -> word stored, no run; Clear+LoadEn -> Count=0.
REQ-034 Reset asserted mid-RUN after 2 issues -> next edge InstrOut=NOP, WriteEnable=0, Count=0, Busy=0; subsequent Start ignored.
REQ-035 After Done, Start again without reload -> identical instruction sequence reissued.
